// File: rtl/pes_uart_tx.sv
// UART transmitter: valid/ready byte in, framed LSB-first serial out, paced by a 1-clk baud tick.
// Optional even parity bit enabled by defining PES_UART_TX_PARITY_EN.
module pes_uart_tx #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 baud_tick_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSync   = 3'd1,
        StStart  = 3'd2,
        StData   = 3'd3,
`ifdef PES_UART_TX_PARITY_EN
        StParity = 3'd4,
`endif
        StStop   = 3'd5
    } state_e;

    localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    state_e                 state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [2:0]             cnt_q;
    logic                   txd_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
`ifdef PES_UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PES_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // A tick arriving with the accept is ignored here, so SYNC aligns to the next one.
                StIdle: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (tx_valid_i && ready_q) begin
                        shift_q  <= tx_data_i;
                        state_q  <= StSync;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef PES_UART_TX_PARITY_EN
                        parity_q <= ^tx_data_i;
`endif
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StSync: begin
                    if (baud_tick_i) begin
                        state_q <= StStart;
                        txd_q   <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_tick_i) begin
                        state_q <= StData;
                        txd_q   <= shift_q[0];
                        cnt_q   <= '0;
                    end
                end
                StData: begin
                    if (baud_tick_i) begin
                        if (cnt_q == LastData) begin
`ifdef PES_UART_TX_PARITY_EN
                            state_q <= StParity;
                            txd_q   <= parity_q;
`else
                            state_q <= StStop;
                            txd_q   <= 1'b1;
                            cnt_q   <= '0;
`endif
                        end else begin
                            shift_q <= shift_q >> 1;
                            cnt_q   <= cnt_q + 3'd1;
                            txd_q   <= shift_q[1];
                        end
                    end
                end
`ifdef PES_UART_TX_PARITY_EN
                StParity: begin
                    if (baud_tick_i) begin
                        state_q <= StStop;
                        txd_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
`endif
                // tx_ready rises one cycle after frame_done, from the IDLE branch.
                StStop: begin
                    if (baud_tick_i) begin
                        if (cnt_q == LastStop) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready_o   = ready_q;
    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: doc/pes_uart_tx.md
Name: pes_uart_tx

Overview:
- UART serial transmitter that consumes the bit-rate tick produced by the team's baud rate generator (iiitb_brg output, retimed to a 1-clk-wide enable pulse).
- Accepts parallel bytes over a valid/ready handshake and emits framed serial data, LSB first: start bit, data bits, optional parity, stop bit(s).
- Sits between the host-side byte source and the txd pad.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset. Assert: async clear. Deassert: synchronous to clk.
- baud_tick  input  1  one-clk-wide pulse, one per bit period.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  source has a byte.
- tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready at a rising clk edge.
- txd  output  1  serial line; idle/mark = 1.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-clk pulse when the final stop bit period ends.

Behaviour:
- Reset values (reset low): state=IDLE, txd=1, tx_ready=1, busy=0, frame_done=0, shift register=0, bit counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SYNC, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: txd=1. On accept, latch tx_data into the shift register and go to SYNC. tx_ready=0 and busy=1 from the next cycle.
- SYNC: waits for the next baud_tick so the start bit is a full bit period. On baud_tick go to START, txd=0 from the following clk.
- START: on baud_tick go to DATA, txd=shift[0], bit counter=0.
- DATA: on each baud_tick, shift right and increment the counter; txd follows the new shift[0].
  - After DATA_BITS ticks in DATA, go to PARITY (feature on) or STOP (feature off).
- STOP: txd=1 for STOP_BITS tick periods. On the last tick go to IDLE; frame_done=1 for exactly that one clk; tx_ready=1 from the next cycle.
- baud_tick is ignored in IDLE.
- baud_tick high in the same cycle as accept: not consumed by SYNC. The start bit is aligned to the next tick.
- Back-to-back frames: tx_valid held high → the next accept occurs the cycle after returning to IDLE, so the next start bit begins at the second tick after the frame ends; gap = one tick period of mark.
- Frame length after SYNC: (1 + DATA_BITS + [1 if parity] + STOP_BITS) tick periods, exact.
- tx_data changes while busy have no effect.
- Reset mid-frame: txd returns to 1 immediately (async). No frame_done pulse. The partial frame is abandoned.
- DATA_BITS < 8: only tx_data[DATA_BITS-1:0] is transmitted.
- Glitch-free txd: txd changes only on the clk edge following a baud_tick, or on reset.

Optional Feature:
- Macro: PES_UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA. txd = even parity (XOR of the transmitted data bits) for one tick period, then STOP. Frame = start + data + parity + stop.
- Undefined: no PARITY state; DATA goes directly to STOP. No parity logic synthesised.

Test Plan:
- Reset: hold reset=0 mid-frame, release → txd=1, tx_ready=1, busy=0, frame_done=0 immediately, and no stray start bit for ≥20 tick periods.
- Single byte 0xA5, baud_tick every 4 clk, 8N1 → txd sequence per tick period 0,1,0,1,0,0,1,0,1,1. Each level lasts exactly 4 clk. frame_done pulses once, 1 clk wide. tx_ready returns high the next cycle.
- Back-to-back 0x00 then 0xFF, tx_valid held high → second accept the cycle after frame_done; exactly one idle tick period of txd=1 between frames; second frame = 0,1×8,1.
- Tick coincident with accept: tx_valid rises in a baud_tick cycle → start bit begins after the next tick and lasts one full period, not one clk.
- STOP_BITS=2, DATA_BITS=7, send 0x7F → 0, seven 1s, 1, 1. Bit 7 of tx_data is ignored.
- PES_UART_TX_PARITY_EN defined: send 0xA5 → parity bit 0; send 0x01 → parity bit 1. Frame is 11 tick periods.
